// File: rtl/wos_window_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wos_window_ctrl_pkg
// Brief   : FSM encoding and window/rank helpers for the weighted order
//           statistic window controller.
// Revision: 1.0 - initial release
// ============================================================================
package wos_window_ctrl_pkg;

    localparam int WOS_CW = 8;

    localparam logic [1:0] C_ST_CLEAR = 2'd0;
    localparam logic [1:0] C_ST_FILL  = 2'd1;
    localparam logic [1:0] C_ST_RUN   = 2'd2;

    // Only the run of ones starting at bit 0 widens the window.
    function automatic logic [WOS_CW-1:0] calc_w(input logic [31:0] k, input int kbits);
        logic              run;
        logic [WOS_CW-1:0] w;
        run = 1'b1;
        w   = WOS_CW'(3);
        for (int i = 0; i < 32; i++) begin
            if (i < kbits) begin
                run = run & k[i];
                if (run) w = w + WOS_CW'(2);
            end
        end
        return w;
    endfunction

    function automatic logic [WOS_CW-1:0] calc_r_eff(input logic [WOS_CW-1:0] rank,
                                                      input logic [WOS_CW-1:0] w);
        if (rank == '0)
            return WOS_CW'(1);
        else if (rank > w)
            return w;
        else
            return rank;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wos_window_ctrl_rank_select.sv
`default_nettype none
// ============================================================================
// Module  : rank_select
// Brief   : Finds the lowest window slot whose rank equals the target rank.
// Revision: 1.0 - initial release
// ============================================================================
module rank_select
    import wos_window_ctrl_pkg::*;
#(
    parameter int N         = 7,
    parameter int RANK_BITS = $clog2(N) + 1,
    parameter int IDXW      = $clog2(N)
) (
    input  logic [RANK_BITS*N-1:0] ranks_in,
    input  logic [RANK_BITS-1:0]   r_eff,
    input  logic [WOS_CW-1:0]      w,
    output logic                   hit,
    output logic [IDXW-1:0]        idx
);

    // Descending scan so the lowest matching slot is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if ((WOS_CW'(j) < w) && (ranks_in[j*RANK_BITS +: RANK_BITS] == r_eff)) begin
                hit = 1'b1;
                idx = IDXW'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wos_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : wos_window_ctrl
// Brief   : Window register, fill/run FSM and output stage for a rank-order
//           filter whose rank datapath lives outside this block.
// Revision: 1.0 - initial release
// ============================================================================
module wos_window_ctrl
    import wos_window_ctrl_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int N         = 7,
    parameter int RANK_BITS = $clog2(N) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_load,
    input  logic [(N-3)/2-1:0]          cfg_k,
    input  logic [RANK_BITS-1:0]        cfg_rank,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_BITS-1:0]        in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_BITS-1:0]        out_data,
    output logic                        dp_shift,
    output logic                        dp_clr_n,
    output logic [(N-3)/2-1:0]          dp_k,
    output logic [DATA_BITS-1:0]        dp_i_new,
    output logic [DATA_BITS*(N-1)-1:0]  dp_s,
    input  logic [RANK_BITS*N-1:0]      ranks_in
);

    localparam int KB   = (N - 3) / 2;
    localparam int IDXW = $clog2(N);

    logic [1:0]                     state_q, state_d;
    logic [KB-1:0]                  k_q, k_d;
    logic [RANK_BITS-1:0]           rank_q, rank_d;
    logic [N-1:0][DATA_BITS-1:0]    win_q, win_d;
    logic [RANK_BITS-1:0]           fill_q, fill_d;
    logic                           pend_q, pend_d;
    logic                           ov_q, ov_d;
    logic [DATA_BITS-1:0]           od_q, od_d;

    logic                           w_run;
    logic [KB-1:0]                  w_k_eff;
    logic [WOS_CW-1:0]              w_w;
    logic [WOS_CW-1:0]              w_r_eff;
    logic                           w_hit;
    logic [IDXW-1:0]                w_idx;
    logic                           w_rdy_st;
    logic                           w_accept;

    always_comb begin
        w_run   = 1'b1;
        w_k_eff = '0;
        for (int i = 0; i < KB; i++) begin
            w_run      = w_run & k_q[i];
            w_k_eff[i] = w_run;
        end
    end

    assign w_w     = calc_w(32'(k_q), KB);
    assign w_r_eff = calc_r_eff(WOS_CW'(rank_q), w_w);

    rank_select #(
        .N         (N),
        .RANK_BITS (RANK_BITS),
        .IDXW      (IDXW)
    ) u_rank_select (
        .ranks_in (ranks_in),
        .r_eff    (RANK_BITS'(w_r_eff)),
        .w        (w_w),
        .hit      (w_hit),
        .idx      (w_idx)
    );

    always_comb begin
        case (state_q)
            C_ST_FILL: w_rdy_st = 1'b1;
            C_ST_RUN:  w_rdy_st = !((ov_q && !out_ready) || pend_q);
            default:   w_rdy_st = 1'b0;
        endcase
    end

    assign in_ready  = w_rdy_st && !cfg_load && !rst;
    assign w_accept  = in_valid && in_ready;
    assign dp_shift  = w_accept;
    assign dp_clr_n  = !(rst || (state_q == C_ST_CLEAR));
    assign dp_k      = w_k_eff;
    assign dp_i_new  = in_data;
    assign dp_s      = win_q[N-2:0];
    assign out_valid = ov_q;
    assign out_data  = od_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        rank_d  = rank_q;
        win_d   = win_q;
        fill_d  = fill_q;
        pend_d  = 1'b0;
        ov_d    = ov_q;
        od_d    = od_q;

        if (ov_q && out_ready)
            ov_d = 1'b0;
        // A fresh result overrides the clear from a same-cycle transfer.
        if (pend_q) begin
            ov_d = 1'b1;
            od_d = w_hit ? win_q[w_idx] : win_q[0];
        end
        if (w_accept)
            win_d = {win_q[N-2:0], in_data};

        case (state_q)
            C_ST_CLEAR: begin
                fill_d  = '0;
                win_d   = '0;
                ov_d    = 1'b0;
                state_d = C_ST_FILL;
            end
            C_ST_FILL: begin
                if (w_accept) begin
                    fill_d = fill_q + RANK_BITS'(1);
                    if (WOS_CW'(fill_q) == (w_w - WOS_CW'(2)))
                        state_d = C_ST_RUN;
                end
            end
            C_ST_RUN: begin
                if (w_accept)
                    pend_d = 1'b1;
            end
            default: state_d = C_ST_CLEAR;
        endcase

        if (cfg_load) begin
            k_d     = cfg_k;
            rank_d  = cfg_rank;
            state_d = C_ST_CLEAR;
            pend_d  = 1'b0;
            ov_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= C_ST_CLEAR;
            k_q     <= '0;
            rank_q  <= RANK_BITS'(2);
            win_q   <= '0;
            fill_q  <= '0;
            pend_q  <= 1'b0;
            ov_q    <= 1'b0;
            od_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            rank_q  <= rank_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            pend_q  <= pend_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wos_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_wos_window_ctrl
// Brief   : Directed self-checking bench with a behavioural rank datapath.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wos_window_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_load;
    logic [1:0]  cfg_k;
    logic [3:0]  cfg_rank;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        dp_shift;
    logic        dp_clr_n;
    logic [1:0]  dp_k;
    logic [7:0]  dp_i_new;
    logic [47:0] dp_s;
    logic [27:0] ranks_in;

    int total = 0;
    int bad   = 0;
    int cur_w = 3;
    int rk;
    logic [7:0] mw [7];

    always #5 clk = ~clk;

    wos_window_ctrl #(.DATA_BITS(8), .N(7), .RANK_BITS(4)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_k(cfg_k), .cfg_rank(cfg_rank),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .dp_shift(dp_shift), .dp_clr_n(dp_clr_n), .dp_k(dp_k), .dp_i_new(dp_i_new),
        .dp_s(dp_s), .ranks_in(ranks_in)
    );

    // Behavioural rank datapath: keeps its own copy of the window and ranks it.
    always @(posedge clk) begin
        if (!dp_clr_n) begin
            for (int i = 0; i < 7; i++) mw[i] <= 8'd0;
        end else if (dp_shift) begin
            mw[0] <= dp_i_new;
            for (int i = 1; i < 7; i++) mw[i] <= mw[i-1];
        end
    end

    always_comb begin
        ranks_in = '0;
        rk = 0;
        for (int j = 0; j < 7; j++) begin
            if (j < cur_w) begin
                rk = 1;
                for (int i = 0; i < 7; i++)
                    if (i < cur_w && (mw[i] < mw[j] || (mw[i] == mw[j] && i < j))) rk++;
                ranks_in[j*4 +: 4] = 4'(rk);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1);
    end

    task automatic push(input logic [7:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        #1;
        while (!in_ready && n < 20) begin
            @(posedge clk); @(negedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL push_timeout data=%0d got in_ready=0 want 1", d);
        end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_cfg(input logic [1:0] k, input logic [3:0] r, input int w);
        cfg_load = 1'b1; cfg_k = k; cfg_rank = r; cur_w = w;
        @(posedge clk); @(negedge clk);
        cfg_load = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
        cfg_load = 1'b1; cfg_k = 2'b11; cfg_rank = 4'd7;
        @(negedge clk); #1;
        total++;
        if (in_ready !== 1'b0 || dp_shift !== 1'b0 || dp_clr_n !== 1'b0) begin
            bad++; $display("FAIL rst_comb got rdy=%b shift=%b clr_n=%b want 0 0 0", in_ready, dp_shift, dp_clr_n);
        end
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || dp_s !== 48'd0 || dp_k !== 2'b00) begin
            bad++; $display("FAIL rst_state got ov=%b od=%0d s=%h k=%b want 0 0 0 00", out_valid, out_data, dp_s, dp_k);
        end
        rst = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; #1;
        total++;
        if (dp_clr_n !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL rst_clear got clr_n=%b rdy=%b want 0 0", dp_clr_n, in_ready);
        end
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (dp_clr_n !== 1'b1 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_fill got clr_n=%b rdy=%b want 1 1", dp_clr_n, in_ready);
        end
    endtask

    task automatic test_median();
        push(8'd3); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL med_fill3 got ov=%b want 0", out_valid); end
        push(8'd9); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL med_fill9 got ov=%b want 0", out_valid); end
        push(8'd1); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL med_pending got ov=%b rdy=%b want 0 0", out_valid, in_ready);
        end
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd3) begin
            bad++; $display("FAIL med_out got ov=%b d=%0d want 1 3", out_valid, out_data);
        end
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL med_consumed got ov=%b want 0", out_valid); end
    endtask

    task automatic test_max_rank();
        do_cfg(2'b11, 4'd7, 7);
        for (int i = 0; i < 6; i++) begin
            push(8'(10 + i)); #1;
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL max_fill%0d got ov=%b want 0", i, out_valid); end
        end
        push(8'd16); #1;
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd16) begin
            bad++; $display("FAIL max_first got ov=%b d=%0d want 1 16", out_valid, out_data);
        end
        push(8'd0); #1;
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd16) begin
            bad++; $display("FAIL max_second got ov=%b d=%0d want 1 16", out_valid, out_data);
        end
    endtask

    task automatic test_backpressure();
        do_cfg(2'b00, 4'd2, 3);
        push(8'd5); push(8'd1);
        out_ready = 1'b0;
        push(8'd8); #1;
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd5) begin
            bad++; $display("FAIL bp_first got ov=%b d=%0d want 1 5", out_valid, out_data);
        end
        in_valid = 1'b1; in_data = 8'd2; #1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (in_ready !== 1'b0 || dp_shift !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'd5) begin
                bad++; $display("FAIL bp_hold%0d got rdy=%b sh=%b ov=%b d=%0d want 0 0 1 5",
                                i, in_ready, dp_shift, out_valid, out_data);
            end
            @(posedge clk); @(negedge clk); #1;
        end
        out_ready = 1'b1; #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got rdy=%b want 1", in_ready); end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_gap got ov=%b want 0", out_valid); end
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd2) begin
            bad++; $display("FAIL bp_resume got ov=%b d=%0d want 1 2", out_valid, out_data);
        end
        push(8'd9); #1;
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd8) begin
            bad++; $display("FAIL bp_next got ov=%b d=%0d want 1 8", out_valid, out_data);
        end
    endtask

    task automatic test_cfg_drop();
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        push(8'd4); #1;
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd4) begin
            bad++; $display("FAIL drop_held got ov=%b d=%0d want 1 4", out_valid, out_data);
        end
        cfg_load = 1'b1; cfg_k = 2'b01; cfg_rank = 4'd3; cur_w = 5;
        in_valid = 1'b1; in_data = 8'd77; #1;
        total++;
        if (in_ready !== 1'b0 || dp_shift !== 1'b0) begin
            bad++; $display("FAIL drop_block got rdy=%b sh=%b want 0 0", in_ready, dp_shift);
        end
        @(posedge clk); @(negedge clk);
        cfg_load = 1'b0; in_valid = 1'b0; #1;
        total++;
        if (out_valid !== 1'b0 || dp_clr_n !== 1'b0 || in_ready !== 1'b0 || dp_k !== 2'b01) begin
            bad++; $display("FAIL drop_clear got ov=%b clr_n=%b rdy=%b k=%b want 0 0 0 01",
                            out_valid, dp_clr_n, in_ready, dp_k);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (dp_clr_n !== 1'b1 || in_ready !== 1'b1) begin
            bad++; $display("FAIL drop_fill got clr_n=%b rdy=%b want 1 1", dp_clr_n, in_ready);
        end
        push(8'd7); push(8'd3); push(8'd11); push(8'd6); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL drop_w5fill got ov=%b want 0", out_valid); end
        push(8'd2); #1;
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd6) begin
            bad++; $display("FAIL drop_w5out got ov=%b d=%0d want 1 6", out_valid, out_data);
        end
    endtask

    task automatic test_rank_clamp();
        do_cfg(2'b01, 4'd0, 5);
        push(8'd20); push(8'd40); push(8'd10); push(8'd50); push(8'd30); #1;
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd10) begin
            bad++; $display("FAIL clamp_low got ov=%b d=%0d want 1 10", out_valid, out_data);
        end
        do_cfg(2'b01, 4'd15, 5);
        push(8'd20); push(8'd40); push(8'd10); push(8'd50); push(8'd30); #1;
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd50) begin
            bad++; $display("FAIL clamp_high got ov=%b d=%0d want 1 50", out_valid, out_data);
        end
    endtask

    task automatic test_reset_midrun();
        do_cfg(2'b10, 4'd3, 3);
        #1;
        total++;
        if (dp_k !== 2'b00) begin bad++; $display("FAIL k_mask got dp_k=%b want 00", dp_k); end
        push(8'd1); push(8'd2); push(8'd3); #1;
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd3) begin
            bad++; $display("FAIL k_w3max got ov=%b d=%0d want 1 3", out_valid, out_data);
        end
        in_valid = 1'b1; in_data = 8'd7; rst = 1'b1; #1;
        total++;
        if (dp_shift !== 1'b0 || in_ready !== 1'b0 || dp_clr_n !== 1'b0) begin
            bad++; $display("FAIL midrst_comb got sh=%b rdy=%b clr_n=%b want 0 0 0", dp_shift, in_ready, dp_clr_n);
        end
        @(posedge clk); @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; cur_w = 3; #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || dp_s !== 48'd0 || dp_clr_n !== 1'b0) begin
            bad++; $display("FAIL midrst_state got ov=%b d=%0d s=%h clr_n=%b want 0 0 0 0",
                            out_valid, out_data, dp_s, dp_clr_n);
        end
        @(posedge clk); @(negedge clk);
        push(8'd5); push(8'd6); push(8'd4); #1;
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd5) begin
            bad++; $display("FAIL midrst_median got ov=%b d=%0d want 1 5", out_valid, out_data);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_load = 1'b0; cfg_k = 2'b00; cfg_rank = 4'd0;
        in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
        test_reset();
        test_median();
        test_max_rank();
        test_backpressure();
        test_cfg_drop();
        test_rank_clamp();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
